// File: rtl/prio_encoder_n_pkg.sv
// Shared helpers for the N-input priority encoder: index-width derivation
// and multi-hot detection.
package prio_encoder_n_pkg;

   localparam int unsigned MAX_N = 1024;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 31; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

   // Clearing the lowest set bit leaves something only when two or more bits were set.
   function automatic logic multi_hot(input logic [MAX_N-1:0] v);
      return |(v & (v - {{(MAX_N-1){1'b0}}, 1'b1}));
   endfunction

endpackage

// File: rtl/prio_encoder_n_scan.sv
// Combinational wrapping priority search: starts at 'start' and walks upward
// (dir=0) or downward (dir=1) around the vector, reporting the first set bit.
module prio_scan #(
   parameter int unsigned N = 8,
   parameter int unsigned W = 3
) (
   input  logic [N-1:0] vec,
   input  logic [W-1:0] start,
   input  logic         dir,
   output logic [W-1:0] idx,
   output logic         found
);

   logic [N-1:0]   src;
   logic [2*N-1:0] rot;
   logic [W-1:0]   st;
   int unsigned    j;
   int unsigned    pos;

   // A downward search is an upward search over the bit-reversed vector.
   always_comb begin
      src   = vec;
      st    = start;
      found = 1'b0;
      j     = 0;
      if (dir) begin
         for (int unsigned i = 0; i < N; i++) src[i] = vec[N-1-i];
         st = W'(N - 1 - 32'(start));
      end
      rot = {src, src} >> st;
      for (int unsigned i = 0; i < N; i++) begin
         if (rot[i] && !found) begin
            found = 1'b1;
            j     = i;
         end
      end
      pos = (32'(st) + j) % N;
      idx = dir ? W'(N - 1 - pos) : W'(pos);
      if (!found) idx = '0;
   end

endmodule

// File: rtl/prio_encoder_n.sv
// Registered N-input priority encoder with valid/ready handshake, zero/multi-hot
// flags and saturating multi-hot counter. PRIO_ENCODER_ROUND_ROBIN_EN selects rotating priority.
module prio_encoder_n
   import prio_encoder_n_pkg::*;
#(
   parameter int unsigned N         = 8,
   parameter int unsigned MSB_FIRST = 1,
   parameter int unsigned CNT_W     = 8,
   localparam int unsigned W        = clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     w,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     y,
   output logic             out_zero,
   output logic             out_multi,
   output logic [CNT_W-1:0] err_cnt,
   input  logic             err_clr
);

   logic         cap;
   logic         multi;
   logic         found;
   logic [W-1:0] win;
   logic [W-1:0] start;
   logic         dir;

   assign in_ready = !out_valid || out_ready;
   assign cap      = in_valid && in_ready;
   assign multi    = multi_hot({{(MAX_N-N){1'b0}}, w});

`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
   logic [W-1:0] ptr;

   assign start = ptr;
   assign dir   = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (cap && found) begin
         ptr <= (win == W'(N - 1)) ? '0 : win + 1'b1;
      end
   end
`else
   assign start = (MSB_FIRST != 0) ? W'(N - 1) : '0;
   assign dir   = (MSB_FIRST != 0);
`endif

   prio_scan #(.N(N), .W(W)) u_scan (
      .vec   (w),
      .start (start),
      .dir   (dir),
      .idx   (win),
      .found (found)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         y         <= '0;
         out_zero  <= 1'b0;
         out_multi <= 1'b0;
      end else if (cap) begin
         out_valid <= 1'b1;
         y         <= win;
         out_zero  <= !found;
         out_multi <= multi;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (err_clr) begin
         err_cnt <= '0;
      end else if (cap && multi && (err_cnt != '1)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_prio_encoder_n.sv
// Scoreboard bench: two encoders (MSB-first/CNT_W=2 and LSB-first/CNT_W=8)
// share stimulus; a spec-level model queues expected results for a negedge monitor.
module tb_prio_encoder_n;

   localparam int unsigned N = 8;

   typedef struct packed {
      logic [2:0] y;
      logic       z;
      logic       m;
   } res_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         err_clr = 1'b0;
   logic [N-1:0] w = '0;

   logic       rdy0, rdy1, ov0, ov1, z0, z1, m0, m1;
   logic [2:0] y0, y1;
   logic [1:0] cnt0;
   logic [7:0] cnt1;

   res_t        q0[$];
   res_t        q1[$];
   logic        mv = 1'b0;
   int unsigned e0 = 0;
   int unsigned e1 = 0;
   int unsigned p0 = 0;
   int unsigned p1 = 0;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   prio_encoder_n #(.N(8), .MSB_FIRST(1), .CNT_W(2)) u_msb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .w(w),
      .out_valid(ov0), .out_ready(out_ready), .y(y0), .out_zero(z0),
      .out_multi(m0), .err_cnt(cnt0), .err_clr(err_clr)
   );

   prio_encoder_n #(.N(8), .MSB_FIRST(0), .CNT_W(8)) u_lsb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .w(w),
      .out_valid(ov1), .out_ready(out_ready), .y(y1), .out_zero(z1),
      .out_multi(m1), .err_cnt(cnt1), .err_clr(err_clr)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int unsigned popc(input logic [N-1:0] v);
      int unsigned c;
      c = 0;
      for (int k = 0; k < N; k++) if (v[k]) c++;
      return c;
   endfunction

`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
   function automatic res_t ref_rr(input logic [N-1:0] v, input int unsigned ptr);
      res_t r;
      r   = '0;
      r.z = (popc(v) == 0);
      r.m = (popc(v) > 1);
      for (int k = N - 1; k >= 0; k--) begin
         if (v[(ptr + k) % N]) r.y = 3'((ptr + k) % N);
      end
      return r;
   endfunction
`else
   function automatic res_t ref_enc(input logic [N-1:0] v, input bit msb);
      res_t r;
      r   = '0;
      r.z = (popc(v) == 0);
      r.m = (popc(v) > 1);
      if (msb) begin
         for (int k = 0; k < N; k++) if (v[k]) r.y = 3'(k);
      end else begin
         for (int k = N - 1; k >= 0; k--) if (v[k]) r.y = 3'(k);
      end
      return r;
   endfunction
`endif

   // Reference model: decides captures from its own view of the output register.
   initial begin : model
      bit   cap;
      res_t r0, r1;
      forever begin
         @(posedge clk);
         if (rst) begin
            q0.delete();
            q1.delete();
            mv = 1'b0;
            e0 = 0;
            e1 = 0;
            p0 = 0;
            p1 = 0;
         end else begin
            cap = in_valid && (!mv || out_ready);
            if (cap) begin
`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
               r0 = ref_rr(w, p0);
               r1 = ref_rr(w, p1);
               if (w != 0) begin
                  p0 = (r0.y == 3'(N - 1)) ? 0 : int'(r0.y) + 1;
                  p1 = (r1.y == 3'(N - 1)) ? 0 : int'(r1.y) + 1;
               end
`else
               r0 = ref_enc(w, 1'b1);
               r1 = ref_enc(w, 1'b0);
`endif
               q0.push_back(r0);
               q1.push_back(r1);
               mv = 1'b1;
            end else if (out_ready) begin
               mv = 1'b0;
            end
            if (err_clr) begin
               e0 = 0;
               e1 = 0;
            end else if (cap && popc(w) > 1) begin
               if (e0 < 3) e0++;
               if (e1 < 255) e1++;
            end
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("in_ready_msb", 32'(rdy0), 32'(!mv || out_ready));
            chk("in_ready_lsb", 32'(rdy1), 32'(!mv || out_ready));
            chk("out_valid_msb", 32'(ov0), 32'(mv));
            chk("out_valid_lsb", 32'(ov1), 32'(mv));
            chk("err_cnt_msb", 32'(cnt0), e0);
            chk("err_cnt_lsb", 32'(cnt1), e1);
            if (ov0) begin
               if (q0.size() == 0) chk("result_msb_unexpected", 32'(ov0), 32'd0);
               else begin
                  chk("result_msb", 32'({y0, z0, m0}), 32'(q0[0]));
                  if (out_ready) void'(q0.pop_front());
               end
            end
            if (ov1) begin
               if (q1.size() == 0) chk("result_lsb_unexpected", 32'(ov1), 32'd0);
               else begin
                  chk("result_lsb", 32'({y1, z1, m1}), 32'(q1[0]));
                  if (out_ready) void'(q1.pop_front());
               end
            end
         end
      end
   end

   task automatic drive(input logic [N-1:0] vw, input logic v, input logic r, input logic c);
      @(posedge clk);
      #1;
      w         = vw;
      in_valid  = v;
      out_ready = r;
      err_clr   = c;
   endtask

   function automatic logic [N-1:0] rand_vec();
      int unsigned sel;
      sel = $urandom_range(0, 3);
      if (sel == 0) return '0;
      if (sel == 1) return N'(1) << $urandom_range(0, N - 1);
      return N'($urandom);
   endfunction

   initial begin : stim
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", 32'(ov0), 32'd0);
      chk("reset_y", 32'(y0), 32'd0);
      chk("reset_flags", 32'({z0, m0, z1, m1}), 32'd0);
      chk("reset_err_cnt", 32'(cnt1), 32'd0);

      // One-hot capture.
      drive(8'b0000_0100, 1'b1, 1'b1, 1'b0);
      drive('0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("onehot_y_msb", 32'(y0), 32'd2);
      chk("onehot_y_lsb", 32'(y1), 32'd2);
      chk("onehot_flags", 32'({ov0, z0, m0}), 32'b100);

      // Multi-hot priority.
      drive(8'b1001_0010, 1'b1, 1'b1, 1'b0);
      drive('0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
      chk("multi_y_rr", 32'(y0), 32'd4);
`else
      chk("multi_y_msb", 32'(y0), 32'd7);
      chk("multi_y_lsb", 32'(y1), 32'd1);
`endif
      chk("multi_flag", 32'(m0), 32'd1);
      chk("multi_cnt", 32'(cnt0), 32'd1);

      // Zero input followed by a 3-cycle stall.
      drive('0, 1'b1, 1'b1, 1'b0);
      drive('0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_hold", 32'({ov0, y0, z0, m0, rdy0}), 32'b1_000_1_0_0);
         if (i < 2) drive('0, 1'b1, 1'b0, 1'b0);
      end
      drive('0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("stall_release", 32'(ov0), 32'd0);

      // Back-to-back throughput.
      for (int i = 0; i < 16; i++) drive(rand_vec(), 1'b1, 1'b1, 1'b0);
      drive('0, 1'b0, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      chk("throughput_drain", q0.size() + q1.size(), 32'd0);

      // Saturation of the 2-bit counter, then clear beating an increment.
      for (int i = 0; i < 5; i++) drive(8'b1100_0000, 1'b1, 1'b1, 1'b0);
      drive('0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("cnt_saturate", 32'(cnt0), 32'd3);
      drive(8'b0000_0011, 1'b1, 1'b1, 1'b1);
      drive('0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("cnt_clear_wins", 32'({cnt0, cnt1}), 32'd0);

      // Rotating pattern, then reset while a result is pending.
      for (int i = 0; i < 3; i++) drive(8'b0001_0001, 1'b1, 1'b1, 1'b0);
      drive(8'b0001_0001, 1'b1, 1'b0, 1'b0);
      drive('0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("pending_before_rst", 32'(ov0), 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_drops_valid", 32'({ov0, ov1}), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) drive(8'b0001_0001, 1'b1, 1'b1, 1'b0);
      drive('0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
      chk("rr_after_rst_last", 32'(y0), 32'd0);
`else
      chk("after_rst_last", 32'(y1), 32'd0);
`endif

      // Randomised traffic with backpressure and occasional clears.
      for (int i = 0; i < 400; i++) begin
         drive(rand_vec(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 15) == 0));
      end
      drive('0, 1'b0, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      chk("final_drain", q0.size() + q1.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
